// File: rtl/exp_bias_pipe_if.sv
// Handshake and operand/result bundle for exp_bias_pipe.
// Producer side drives the master modport; the pipeline uses the slave modport.
interface exp_bias_pipe_if #(
    parameter int EXP_W = 8
);
    // valid/ready: a beat moves on a rising edge where valid & ready are both high;
    // a producer holding valid keeps its payload stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] exp_a;
    logic [EXP_W-1:0] exp_b;
    logic             norm_inc;
    logic             out_valid;
    logic             out_ready;
    logic [EXP_W-1:0] exp_out;
    logic             ovf;
    logic             unf;
    logic             zero;

    modport master (
        output in_valid, exp_a, exp_b, norm_inc, out_ready,
        input  in_ready, out_valid, exp_out, ovf, unf, zero
    );

    modport slave (
        input  in_valid, exp_a, exp_b, norm_inc, out_ready,
        output in_ready, out_valid, exp_out, ovf, unf, zero
    );
endinterface

// File: rtl/exp_bias_pipe.sv
// Two-stage exponent adder: S1 sums the biased exponents, S2 removes the bias
// and saturates, raising ovf/unf/zero. Holds up to two beats under backpressure.
module exp_bias_pipe #(
    parameter int EXP_W = 8,
    parameter int BIAS  = 127
) (
    input logic           clk,
    input logic           rst,
    exp_bias_pipe_if.slave io
);
    localparam int DW = EXP_W + 2;
    localparam logic signed [DW-1:0] BIAS_D = DW'(BIAS);
    localparam logic signed [DW-1:0] MAX_D  = DW'((1 << EXP_W) - 1);
    localparam logic signed [DW-1:0] ZERO_D = DW'(0);

    logic             s1_v;
    logic [EXP_W:0]   s1_sum;
    logic             s1_z;
    logic             s2_v;
    logic [EXP_W-1:0] s2_exp;
    logic             s2_ovf;
    logic             s2_unf;
    logic             s2_zero;

    logic             s1_load;
    logic             s2_load;
    logic [EXP_W:0]   sum_n;
    logic signed [DW-1:0] d;
    logic [EXP_W-1:0] exp_n;
    logic             ovf_n;
    logic             unf_n;
    logic             zero_n;

    // in_ready may follow out_ready combinationally; out_valid is purely registered.
    assign io.in_ready  = !rst && (!s1_v || !s2_v || io.out_ready);
    assign s1_load      = io.in_valid && io.in_ready;
    assign s2_load      = s1_v && (!s2_v || io.out_ready);

    assign io.out_valid = s2_v;
    assign io.exp_out   = s2_exp;
    assign io.ovf       = s2_ovf;
    assign io.unf       = s2_unf;
    assign io.zero      = s2_zero;

    assign sum_n = {1'b0, io.exp_a} + {1'b0, io.exp_b} + {{EXP_W{1'b0}}, io.norm_inc};
    assign d     = $signed({1'b0, s1_sum}) - BIAS_D;

    always_comb begin
        exp_n  = '0;
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        zero_n = 1'b0;
        if (s1_z) begin
            zero_n = 1'b1;
        end else if (d <= ZERO_D) begin
            unf_n = 1'b1;
        end else if (d >= MAX_D) begin
            exp_n = '1;
            ovf_n = 1'b1;
        end else begin
            exp_n = d[EXP_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_sum  <= '0;
            s1_z    <= 1'b0;
            s2_v    <= 1'b0;
            s2_exp  <= '0;
            s2_ovf  <= 1'b0;
            s2_unf  <= 1'b0;
            s2_zero <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_v   <= 1'b1;
                s1_sum <= sum_n;
                s1_z   <= (io.exp_a == '0) || (io.exp_b == '0);
            end else if (s2_load) begin
                s1_v <= 1'b0;
            end

            // Result registers only change on a load, so a stalled output stays put.
            if (s2_load) begin
                s2_v    <= 1'b1;
                s2_exp  <= exp_n;
                s2_ovf  <= ovf_n;
                s2_unf  <= unf_n;
                s2_zero <= zero_n;
            end else if (io.out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exp_bias_pipe.sv
// Directed and random bench for exp_bias_pipe (EXP_W = 8, BIAS = 127).
// Expected results are {exp_out, ovf, unf, zero} words queued at each accepted input.
module tb_exp_bias_pipe;
    localparam int W = 8;

    logic clk;
    logic rst;

    exp_bias_pipe_if #(.EXP_W(W)) io ();

    exp_bias_pipe #(.EXP_W(W), .BIAS(127)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [W+2:0] exp_q[$];

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+2:0] model(input int a, input int b, input int inc);
        int d;
        d = a + b + inc - 127;
        if (a == 0 || b == 0) return {8'd0, 3'b001};
        if (d <= 0)           return {8'd0, 3'b010};
        if (d >= 255)         return {8'hff, 3'b100};
        return {d[7:0], 3'b000};
    endfunction

    // Driver: present one beat, wait (bounded) for acceptance, queue its expected result.
    task automatic send(input int a, input int b, input int inc, input logic [W+2:0] e);
        bit acc;
        acc = 1'b0;
        io.in_valid = 1'b1;
        io.exp_a    = W'(a);
        io.exp_b    = W'(b);
        io.norm_inc = inc[0];
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (io.in_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("send_accepted", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        io.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: pops on every output transfer, checks hold while stalled.
    logic [W+2:0] held;
    bit           stalled = 1'b0;
    always @(negedge clk) begin
        logic [W+2:0] cur;
        cur = {io.exp_out, io.ovf, io.unf, io.zero};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", 32'(io.out_valid), 32'd1);
                check("stall_hold", 32'(cur), 32'(held));
            end
            if (io.out_valid && io.out_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 32'(io.out_valid), 32'd0);
                else check("result", 32'(cur), 32'(exp_q.pop_front()));
            end
            stalled = io.out_valid && !io.out_ready;
            held    = cur;
        end
    end

    initial begin
        int  idx;
        bit  saw_stall;
        int  a, b, inc;

        rst         = 1'b1;
        io.in_valid = 1'b0;
        io.exp_a    = '0;
        io.exp_b    = '0;
        io.norm_inc = 1'b0;
        io.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready", 32'(io.in_ready), 32'd0);
        check("rst_out_valid", 32'(io.out_valid), 32'd0);
        check("rst_outputs", 32'({io.exp_out, io.ovf, io.unf, io.zero}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(io.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Nominal beat with latency check
        io.in_valid = 1'b1;
        io.exp_a    = 8'd130;
        io.exp_b    = 8'd127;
        io.norm_inc = 1'b0;
        @(negedge clk);
        check("nom_accept", 32'(io.in_ready), 32'd1);
        exp_q.push_back({8'd130, 3'b000});
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("nom_lat1", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("nom_lat2", 32'(io.out_valid), 32'd1);
        @(posedge clk);
        #1;
        idle(2);

        // Saturation boundaries and flags, back to back
        send(191, 190, 0, {8'd254, 3'b000});
        send(191, 190, 1, {8'hff,  3'b100});
        send(200, 200, 0, {8'hff,  3'b100});
        send(64,  64,  0, {8'd1,   3'b000});
        send(64,  63,  0, {8'd0,   3'b010});
        send(10,  20,  0, {8'd0,   3'b010});
        send(0,   200, 1, {8'd0,   3'b001});
        send(255, 255, 1, {8'hff,  3'b100});
        idle(4);
        check("directed_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: six beats, consumer stalls in cycles 2..5
        idx       = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            io.out_ready = !(cyc >= 2 && cyc <= 5);
            if (idx < 6) begin
                io.in_valid = 1'b1;
                io.exp_a    = W'(128 + idx);
                io.exp_b    = 8'd127;
                io.norm_inc = 1'b0;
            end else begin
                io.in_valid = 1'b0;
            end
            @(negedge clk);
            if (io.in_valid && io.in_ready) begin
                exp_q.push_back({W'(128 + idx), 3'b000});
                idx++;
            end else if (io.in_valid) begin
                saw_stall = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        io.out_ready = 1'b1;
        check("bp_accepted", 32'(idx), 32'd6);
        check("bp_ready_drop", 32'(saw_stall), 32'd1);
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: one random beat per cycle, one result per cycle after fill
        for (int i = 0; i < 100; i++) begin
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            inc = $urandom_range(0, 1);
            io.in_valid = 1'b1;
            io.exp_a    = W'(a);
            io.exp_b    = W'(b);
            io.norm_inc = inc[0];
            @(negedge clk);
            check("stream_ready", 32'(io.in_ready), 32'd1);
            exp_q.push_back(model(a, b, inc));
            if (i >= 2) check("stream_valid", 32'(io.out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        idle(4);
        check("stream_drained", 32'(exp_q.size()), 32'd0);

        // Reset while both stages hold a beat
        io.out_ready = 1'b0;
        send(130, 127, 0, {8'd130, 3'b000});
        send(131, 127, 0, {8'd131, 3'b000});
        io.in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_in_ready", 32'(io.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        io.out_ready = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(io.out_valid), 32'd0);
        check("midrst_outputs", 32'({io.exp_out, io.ovf, io.unf, io.zero}), 32'd0);
        check("midrst_in_ready_after", 32'(io.in_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("midrst_no_stale", 32'(io.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        io.in_valid = 1'b1;
        io.exp_a    = 8'd140;
        io.exp_b    = 8'd127;
        io.norm_inc = 1'b0;
        @(negedge clk);
        exp_q.push_back({8'd140, 3'b000});
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
        @(negedge clk);
        check("postrst_lat1", 32'(io.out_valid), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst_lat2", 32'(io.out_valid), 32'd1);
        @(posedge clk);
        #1;
        idle(3);
        check("final_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
